// File: rtl/io_pkg.sv
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared I/O constants: input port select and debounce defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package io_pkg;

    // Input port 0 lives at 90h; the select decodes addr[7:2].
    localparam logic [5:0] IO_IN_PORT0_SEL = 6'b100100;

    localparam int IO_WORD_W      = 32;
    localparam int DEB_TICK_DIV   = 50000;
    localparam int DEB_STABLE_CNT = 4;

    // Width for a counter holding 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
// Module   : debounce_bit
// Purpose  : Two-flop synchroniser, disagreement counter and stable flop for
//            one switch line, advanced only on the shared sample tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debounce_bit
    import io_pkg::*;
#(
    parameter int STABLE_CNT = DEB_STABLE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic stable,
    output logic accept
);

    localparam int             CW       = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CNT - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] dis_cnt;
    logic          stable_q;
    logic          differ;

    assign differ = sync_q2 ^ stable_q;
    // Acceptance clears the counter, so it can never wrap past CNT_LAST.
    assign accept = tick & differ & (dis_cnt == CNT_LAST);
    assign stable = stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            dis_cnt  <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (tick) begin
                if (!differ) begin
                    dis_cnt <= '0;
                end else if (dis_cnt == CNT_LAST) begin
                    stable_q <= sync_q2;
                    dis_cnt  <= '0;
                end else begin
                    dis_cnt <= dis_cnt + CW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_switch_debounce.sv
// ============================================================================
// Module   : io_switch_debounce
// Purpose  : Synchronise and debounce raw switch lines into the stable word
//            feeding in_port0 (90h), with a one-cycle change strobe.
//            Optional macro IO_DEBOUNCE_EDGE_EN builds per-bit rise pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_switch_debounce
    import io_pkg::*;
#(
    parameter int WIDTH      = IO_WORD_W,
    parameter int TICK_DIV   = DEB_TICK_DIV,
    parameter int STABLE_CNT = DEB_STABLE_CNT
) (
    input  logic             io_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] port_word,
    output logic             changed,
    output logic [WIDTH-1:0] edge_rise
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [WIDTH-1:0] accept;
    logic             changed_q;

    // With TICK_DIV=1 the counter sits at 0 and tick is permanently high.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge io_clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            debounce_bit #(
                .STABLE_CNT (STABLE_CNT)
            ) u_debounce_bit (
                .clk    (io_clk),
                .rst    (reset),
                .raw    (raw_in[i]),
                .tick   (tick),
                .stable (port_word[i]),
                .accept (accept[i])
            );
        end
    endgenerate

    // Set on the same edge that updates port_word, so the pulse marks the
    // first cycle the new word is visible.
    always_ff @(posedge io_clk) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept;
        end
    end

    assign changed = changed_q;

`ifdef IO_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q;

    always_ff @(posedge io_clk) begin
        if (reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= accept & ~port_word;
        end
    end

    assign edge_rise = rise_q;
`else
    assign edge_rise = '0;
`endif

endmodule

`default_nettype wire
